bus_dev_fifo: RTL and testbench
===============================

# bus_dev_fifo

Per-device transmit FIFO feeding one device port of `bs_gnrtr_n_rbtr`. The host side writes packets, and the bus side sees `pndng` with the head packet on `D_pop`. The arbiter consumes packets with `pop`. One instance per (bit, driver) slot; outputs connect directly to `pndng[b][d]` and `D_pop[b][d]`, and the bus's `pop[b][d]` drives the input.

## Interface
Parameters:
- `pckg_sz`, 16: packet width in bits; top 8 bits are the destination ID.
- `depth`, 8: number of entries; any value ≥ 2, power of two not required.
- `broadcast`, 8'hFF: destination ID meaning "all devices"; carried through unchanged, used only for statistics.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `push_in` in 1: host write strobe.
- `data_in` in `pckg_sz`: host packet.
- `full` out 1: no free entry.
- `pndng` out 1: FIFO non-empty, to bus.
- `D_pop` out `pckg_sz`: head packet, to bus.
- `pop` in 1: bus consumes head.
- `count` out `$clog2(depth+1)`: current occupancy.
- `overflow` out 1: sticky, push dropped while full.
- `underflow` out 1: sticky, pop while empty.
- `clr_flags` in 1: synchronous clear of sticky flags.

## Operation
- Storage is a circular buffer with `wr_ptr`, `rd_ptr` in `0..depth-1` and `count` in `0..depth`. Pointers wrap from `depth-1` to 0 by explicit compare, not modulo-2^n.
- Push accepted: `mem[wr_ptr] <= data_in`, `wr_ptr` advances.
- Push when `count==depth` and no pop: packet dropped, `overflow <= 1`, pointers unchanged.
- Pop accepted when `count>0`: `rd_ptr` advances.
- Pop when `count==0`: ignored, `underflow <= 1`.
- Push and pop together, not empty: both performed; `count` unchanged. This holds when full: a slot is freed and refilled in the same edge, with no overflow.
- Push and pop together, empty: push accepted, pop ignored, `underflow <= 1`, `count` becomes 1.
- `pndng = (count != 0)`; `full = (count == depth)`.
- `D_pop = mem[rd_ptr]` when `pndng`, else all-zero. This is first-word fall-through.
- `clr_flags` clears `overflow` and `underflow`. An event in the same cycle wins, and the flag stays 1.

## Timing
- Reset asserted (low), at any time including mid-transfer: immediately `count=0`, pointers 0, `pndng=0`, `full=0`, `D_pop=0`, `overflow=0`, `underflow=0`, and the overflow counter is 0. Memory contents are not reset.
- Reset release is sampled at the next rising `clk`; `push_in` is honoured on the first edge after release.
- Push-to-`pndng` latency: 1 cycle. A packet pushed at edge N is visible on `D_pop` with `pndng=1` after edge N.
- Pop-to-next-head latency: 0 extra cycles. After the pop edge, `D_pop` shows the next entry, or 0 if empty.
- `full`, `count` and `pndng` update only on rising `clk`.
- The bus may hold `pop` for one cycle per packet. Each cycle `pop=1` with `pndng=1` consumes exactly one packet.

## Configuration
- `BUS_FIFO_OVF_CNT_EN` defined: adds output `ovf_cnt` (16 bits). It increments on every dropped push, saturates at 16'hFFFF, is cleared by `clr_flags`, and resets to 0.
- Not defined: the port and counter are absent; only the sticky `overflow` flag exists.

## Structure
- Shared package `bus_pkg` holds:
  - default `PCKG_SZ`;
  - `BROADCAST` constant;
  - typedef `pkt_t` (`logic [PCKG_SZ-1:0]`);
  - helper function `pkt_dest(pkt_t)` returning the top 8 bits.
- One natural sub-module is `bus_fifo_mem`: a `depth`×`pckg_sz` register array with one write port and an asynchronous read port. Pointer, count and flag control stays in `bus_dev_fifo`.

## Test plan
- Reset low mid-stream with 3 entries queued: `count=0`, `pndng=0` and `D_pop=0` immediately, before any clock edge.
- Push 16'h01AA then 16'h02BB, then pop twice. Expected: `D_pop` is 16'h01AA one cycle after the first push, then 16'h02BB after the first pop; `pndng=0` after the second pop.
- Push 9 packets with `depth=8`, no pops. Expected: `full=1` after the 8th, the 9th is dropped, `overflow=1`, and `ovf_cnt=1` when the macro is defined. Popping 8 times then returns the first 8 packets in order.
- Full FIFO, push 16'hFF55 and pop in the same cycle: `count` stays 8, `overflow` stays 0, and 16'hFF55 is the 8th packet out.
- Empty FIFO, push 16'h0312 and pop in the same cycle: `count=1`, `D_pop=16'h0312`, `underflow=1`. Then `clr_flags` for one cycle gives `underflow=0`.
- 20 push/pop pairs with `depth=5` to exercise pointer wrap-around: output order matches input order, and `count` never exceeds 5.

Source files
------------

// File: rtl/bus_pkg.sv
// bus_pkg: shared packet type, default sizes and helpers for bus device FIFOs
package bus_pkg;
  localparam int PCKG_SZ = 16;
  localparam logic [7:0] BROADCAST = 8'hFF;
  typedef logic [PCKG_SZ-1:0] pkt_t;
  function automatic logic [7:0] pkt_dest(pkt_t p);
    return p[PCKG_SZ-1 -: 8];
  endfunction
endpackage

// File: rtl/bus_fifo_mem.sv
// bus_fifo_mem: depth x w register array, one write port, asynchronous read port
// ports: clk; we/waddr/wdata write side; raddr -> rdata combinational read
module bus_fifo_mem
  import bus_pkg::*;
#(
  parameter int depth = 8,
  parameter int w = PCKG_SZ,
  parameter int aw = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [aw-1:0] waddr,
  input  logic [w-1:0]  wdata,
  input  logic [aw-1:0] raddr,
  output logic [w-1:0]  rdata
);
  logic [w-1:0] mem [depth];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/bus_dev_fifo.sv
// bus_dev_fifo: per-device first-word fall-through transmit FIFO feeding one bus port
// ports: clk, reset (async active-low); host push_in/data_in, full; bus pndng/D_pop/pop;
// count occupancy; sticky overflow/underflow cleared by clr_flags;
// ovf_cnt (16-bit saturating dropped-push counter) only when BUS_FIFO_OVF_CNT_EN is defined
module bus_dev_fifo
  import bus_pkg::*;
#(
  parameter int pckg_sz = PCKG_SZ,
  parameter int depth = 8,
  parameter logic [7:0] broadcast = BROADCAST
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_in,
  input  logic [pckg_sz-1:0]           data_in,
  output logic                         full,
  output logic                         pndng,
  output logic [pckg_sz-1:0]           D_pop,
  input  logic                         pop,
  output logic [$clog2(depth+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow,
`ifdef BUS_FIFO_OVF_CNT_EN
  output logic [15:0]                  ovf_cnt,
`endif
  input  logic                         clr_flags
);
  localparam int aw = $clog2(depth);
  localparam int cw = $clog2(depth+1);
  logic [aw-1:0] wr_ptr, rd_ptr;
  logic [pckg_sz-1:0] rd_data;
  logic do_push, do_pop, drop, under;
  assign pndng = count != '0;
  assign full = count == cw'(depth);
  assign do_pop = pop && pndng;
  // a pop on a full FIFO frees the slot the simultaneous push refills
  assign do_push = push_in && (!full || pop);
  assign drop = push_in && full && !pop;
  assign under = pop && !pndng;
  assign D_pop = pndng ? rd_data : '0;
  bus_fifo_mem #(.depth(depth), .w(pckg_sz), .aw(aw)) u_mem (
    .clk(clk),
    .we(do_push),
    .waddr(wr_ptr),
    .wdata(data_in),
    .raddr(rd_ptr),
    .rdata(rd_data)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr == aw'(depth-1) ? '0 : wr_ptr + aw'(1);
      if (do_pop) rd_ptr <= rd_ptr == aw'(depth-1) ? '0 : rd_ptr + aw'(1);
      count <= count + cw'(do_push) - cw'(do_pop);
      overflow <= drop || (overflow && !clr_flags);
      underflow <= under || (underflow && !clr_flags);
    end
`ifdef BUS_FIFO_OVF_CNT_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) ovf_cnt <= '0;
    else if (drop) ovf_cnt <= ovf_cnt == 16'hFFFF ? ovf_cnt : ovf_cnt + 16'd1;
    else if (clr_flags) ovf_cnt <= '0;
`endif
endmodule

// File: tb/tb_bus_dev_fifo.sv
// tb_bus_dev_fifo: directed self-checking bench with a queue model for depth-8 and depth-5 FIFOs
module tb_bus_dev_fifo;
  logic clk = 0;
  logic reset = 0;
  logic clr = 0;
  logic push8 = 0, pop8 = 0, push5 = 0, pop5 = 0;
  logic [15:0] d8 = 0, d5 = 0;
  logic full8, pndng8, overflow8, underflow8, full5, pndng5, overflow5, underflow5;
  logic [15:0] D_pop8, D_pop5;
  logic [3:0] count8;
  logic [2:0] count5;
`ifdef BUS_FIFO_OVF_CNT_EN
  logic [15:0] ovf_cnt8, ovf_cnt5;
`endif
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  bus_dev_fifo #(.pckg_sz(16), .depth(8)) u8 (
    .clk(clk), .reset(reset), .push_in(push8), .data_in(d8), .full(full8),
    .pndng(pndng8), .D_pop(D_pop8), .pop(pop8), .count(count8),
    .overflow(overflow8), .underflow(underflow8),
`ifdef BUS_FIFO_OVF_CNT_EN
    .ovf_cnt(ovf_cnt8),
`endif
    .clr_flags(clr)
  );

  bus_dev_fifo #(.pckg_sz(16), .depth(5)) u5 (
    .clk(clk), .reset(reset), .push_in(push5), .data_in(d5), .full(full5),
    .pndng(pndng5), .D_pop(D_pop5), .pop(pop5), .count(count5),
    .overflow(overflow5), .underflow(underflow5),
`ifdef BUS_FIFO_OVF_CNT_EN
    .ovf_cnt(ovf_cnt5),
`endif
    .clr_flags(clr)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  logic [15:0] q8[$], q5[$];
  logic ov8 = 0, un8 = 0, ov5 = 0, un5 = 0;
  logic [15:0] oc8 = 0, oc5 = 0;
  int n8, n5;
  logic dr8, dr5;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q8 = {}; q5 = {};
      ov8 = 0; un8 = 0; oc8 = 0; ov5 = 0; un5 = 0; oc5 = 0;
    end else begin
      n8 = q8.size();
      dr8 = push8 && n8 == 8 && !pop8;
      ov8 = dr8 ? 1'b1 : clr ? 1'b0 : ov8;
      oc8 = dr8 ? (oc8 == 16'hFFFF ? oc8 : oc8 + 16'd1) : clr ? 16'h0 : oc8;
      un8 = (pop8 && n8 == 0) ? 1'b1 : clr ? 1'b0 : un8;
      if (pop8 && n8 > 0) void'(q8.pop_front());
      if (push8 && (n8 < 8 || pop8)) q8.push_back(d8);
      n5 = q5.size();
      dr5 = push5 && n5 == 5 && !pop5;
      ov5 = dr5 ? 1'b1 : clr ? 1'b0 : ov5;
      oc5 = dr5 ? (oc5 == 16'hFFFF ? oc5 : oc5 + 16'd1) : clr ? 16'h0 : oc5;
      un5 = (pop5 && n5 == 0) ? 1'b1 : clr ? 1'b0 : un5;
      if (pop5 && n5 > 0) void'(q5.pop_front());
      if (push5 && (n5 < 5 || pop5)) q5.push_back(d5);
    end
  end

  always @(negedge clk) begin
    chk("m8_count", 32'(count8), 32'(q8.size()));
    chk("m8_pndng", 32'(pndng8), 32'(q8.size() != 0));
    chk("m8_full", 32'(full8), 32'(q8.size() == 8));
    chk("m8_dpop", 32'(D_pop8), 32'(q8.size() != 0 ? q8[0] : 16'h0));
    chk("m8_ovf", 32'(overflow8), 32'(ov8));
    chk("m8_unf", 32'(underflow8), 32'(un8));
    chk("m5_count", 32'(count5), 32'(q5.size()));
    chk("m5_pndng", 32'(pndng5), 32'(q5.size() != 0));
    chk("m5_full", 32'(full5), 32'(q5.size() == 5));
    chk("m5_dpop", 32'(D_pop5), 32'(q5.size() != 0 ? q5[0] : 16'h0));
    chk("m5_ovf", 32'(overflow5), 32'(ov5));
    chk("m5_unf", 32'(underflow5), 32'(un5));
`ifdef BUS_FIFO_OVF_CNT_EN
    chk("m8_ovfcnt", 32'(ovf_cnt8), 32'(oc8));
    chk("m5_ovfcnt", 32'(ovf_cnt5), 32'(oc5));
`endif
  end

  task automatic step(input logic p8, input logic [15:0] dd8, input logic o8,
                      input logic p5, input logic [15:0] dd5, input logic o5, input logic c);
    push8 = p8; d8 = dd8; pop8 = o8; push5 = p5; d5 = dd5; pop5 = o5; clr = c;
    @(negedge clk);
    push8 = 0; pop8 = 0; push5 = 0; pop5 = 0; clr = 0;
  endtask

  task automatic s8(input logic p, input logic [15:0] d, input logic o, input logic c);
    step(p, d, o, 1'b0, 16'h0, 1'b0, c);
  endtask

  task automatic s5(input logic p, input logic [15:0] d, input logic o, input logic c);
    step(1'b0, 16'h0, 1'b0, p, d, o, c);
  endtask

  initial begin
    int out;
    repeat (2) @(negedge clk);
    chk("rst_count", 32'(count8), 0);
    chk("rst_ovf", 32'(overflow8), 0);
    reset = 1;
    s8(1, 16'h01AA, 0, 0);
    chk("fwft_first", 32'(D_pop8), 32'h01AA);
    chk("pndng_first", 32'(pndng8), 1);
    s8(1, 16'h02BB, 0, 0);
    s8(0, 16'h0, 1, 0);
    chk("head_after_pop", 32'(D_pop8), 32'h02BB);
    s8(0, 16'h0, 1, 0);
    chk("pndng_empty", 32'(pndng8), 0);
    chk("dpop_empty", 32'(D_pop8), 0);
    for (int i = 0; i < 9; i++) begin
      s8(1, 16'(16'h1000 + i), 0, 0);
      if (i == 7) chk("full_at_8", 32'(full8), 1);
    end
    chk("ovf_set", 32'(overflow8), 1);
    chk("cnt_full", 32'(count8), 8);
`ifdef BUS_FIFO_OVF_CNT_EN
    chk("ovf_cnt_1", 32'(ovf_cnt8), 1);
`endif
    s8(0, 16'h0, 0, 1);
    chk("ovf_clr", 32'(overflow8), 0);
    chk("head_1000", 32'(D_pop8), 32'h1000);
    s8(1, 16'hFF55, 1, 0);
    chk("cnt_keep_full", 32'(count8), 8);
    chk("ovf_stays0", 32'(overflow8), 0);
    for (int i = 0; i < 8; i++) begin
      chk("drain_order", 32'(D_pop8), i == 7 ? 32'hFF55 : 32'(16'h1001 + i));
      s8(0, 16'h0, 1, 0);
    end
    chk("drained", 32'(count8), 0);
    s8(1, 16'h0312, 1, 0);
    chk("empty_pp_cnt", 32'(count8), 1);
    chk("empty_pp_dpop", 32'(D_pop8), 32'h0312);
    chk("empty_pp_unf", 32'(underflow8), 1);
    s8(0, 16'h0, 0, 1);
    chk("unf_clr", 32'(underflow8), 0);
    s8(0, 16'h0, 1, 0);
    s8(0, 16'h0, 1, 1);
    chk("unf_event_wins", 32'(underflow8), 1);
    s8(0, 16'h0, 0, 1);
    for (int i = 0; i < 3; i++) s8(1, 16'(16'h2000 + i), 0, 0);
    chk("pre_rst_cnt", 32'(count8), 3);
    @(posedge clk);
    #2 reset = 0;
    #1;
    chk("arst_count", 32'(count8), 0);
    chk("arst_pndng", 32'(pndng8), 0);
    chk("arst_dpop", 32'(D_pop8), 0);
    chk("arst_full", 32'(full8), 0);
    @(negedge clk);
    reset = 1;
    s8(1, 16'h3000, 0, 0);
    chk("post_rst_push", 32'(D_pop8), 32'h3000);
    s8(0, 16'h0, 1, 0);
    for (int i = 0; i < 5; i++) s5(1, 16'(16'h5000 + i), 0, 0);
    chk("full5", 32'(full5), 1);
    s5(1, 16'hDEAD, 0, 0);
    chk("ovf5", 32'(overflow5), 1);
    chk("cnt5_after_drop", 32'(count5), 5);
    s5(0, 16'h0, 0, 1);
    out = 0;
    for (int i = 0; i < 20; i++) begin
      chk("wrap_order", 32'(D_pop5), 32'(16'h5000 + out));
      chk("cnt5_bound", 32'(count5 <= 3'd5), 1);
      s5(1, 16'(16'h5005 + i), 1, 0);
      out++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("wrap_drain", 32'(D_pop5), 32'(16'h5000 + out));
      s5(0, 16'h0, 1, 0);
      out++;
    end
    chk("cnt5_empty", 32'(count5), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
